serial_subtractor: RTL

//   Multi-cycle, digit-serial subtractor: computes d = a - b - bin over WIDTH bits,

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, DIGIT bits per clock.
// Borrow ripples between cycles through a register; start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   diff;
    logic [WIDTH-1:0] r_next;

    // One digit of the subtraction; bit DIGIT is set when the digit wraps.
    always_comb begin
        diff = {1'b0, a_q[DIGIT-1:0]}
             - {1'b0, b_q[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, brw_q};
        r_next = r_q >> DIGIT;
        r_next[WIDTH-1 -: DIGIT] = diff[DIGIT-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        brw_d   = brw_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    r_d     = '0;
                    brw_d   = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                r_d   = r_next;
                brw_d = diff[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    dout_d  = r_next;
                    bout_d  = diff[DIGIT];
                    ovf_d   = (amsb_q != bmsb_q) && (r_next[WIDTH-1] != amsb_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            brw_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            brw_q   <= brw_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = dout_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
